rv32i_fetch_decode_queue: RTL and testbench

//  Execute-side receiver for fetch->execute instruction packets (token/pc/pc4/instr/prediction).

---
 rtl/rv32i_fetch_decode_queue.sv | 211 +++++++++++++++++++++
 tb/tb_rv32i_fetch_decode_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_decode_queue.sv
// Execute-side instruction queue: buffers fetch packets in a DEPTH-entry FIFO
// and presents the head entry decoded into RV32I fields.
module rv32i_fetch_decode_queue #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    input  logic                     fetch_token,
    output logic                     fetch_ready,
    input  logic [31:0]              fetch_pc,
    input  logic [31:0]              fetch_pc4,
    input  logic [31:0]              fetch_instr,
    input  logic [31:0]              fetch_pred,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [31:0]              dec_pc,
    output logic [31:0]              dec_pc4,
    output logic [31:0]              dec_pred,
    output logic [6:0]               dec_opcode,
    output logic [2:0]               dec_funct3,
    output logic [6:0]               dec_funct7,
    output logic [4:0]               dec_rd,
    output logic [4:0]               dec_rs1,
    output logic [4:0]               dec_rs2,
    output logic [31:0]              dec_imm,
    output logic                     dec_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [6:0] {
        OP_LUI     = 7'b0110111,
        OP_AUIPC   = 7'b0010111,
        OP_JAL     = 7'b1101111,
        OP_JALR    = 7'b1100111,
        OP_BRANCH  = 7'b1100011,
        OP_LOAD    = 7'b0000011,
        OP_STORE   = 7'b0100011,
        OP_IMMED   = 7'b0010011,
        OP_REGREG  = 7'b0110011,
        OP_SYSTEM  = 7'b1110011,
        OP_MISCMEM = 7'b0001111
    } opcode_e;

    logic [31:0] pc_q    [DEPTH];
    logic [31:0] pc4_q   [DEPTH];
    logic [31:0] instr_q [DEPTH];
    logic [31:0] pred_q  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    assign fetch_ready = (count_q != CW'(DEPTH));
    assign dec_valid   = (count_q != '0);
    assign count       = count_q;

    assign push = fetch_token && fetch_ready && !flush;
    assign pop  = dec_valid && dec_ready && !flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: every read is gated by occupancy.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_q[wr_ptr]    <= fetch_pc;
            pc4_q[wr_ptr]   <= fetch_pc4;
            instr_q[wr_ptr] <= fetch_instr;
            pred_q[wr_ptr]  <= fetch_pred;
        end
    end

    logic [31:0] head_instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm;
    logic        illegal;

    assign head_instr = instr_q[rd_ptr];
    assign op         = head_instr[6:0];
    assign f3         = head_instr[14:12];
    assign f7         = head_instr[31:25];

    assign imm_i = {{20{head_instr[31]}}, head_instr[31:20]};
    assign imm_s = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
    assign imm_b = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                    head_instr[30:25], head_instr[11:8], 1'b0};
    assign imm_u = {head_instr[31:12], 12'h000};
    assign imm_j = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                    head_instr[20], head_instr[30:21], 1'b0};

    always_comb begin
        illegal = 1'b0;
        imm     = '0;
        case (op)
            OP_LUI, OP_AUIPC: begin
                imm = imm_u;
            end
            OP_JAL: begin
                imm = imm_j;
            end
            OP_JALR: begin
                imm     = imm_i;
                illegal = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                imm     = imm_b;
                illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LOAD: begin
                imm     = imm_i;
                illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                imm     = imm_s;
                illegal = (f3 > 3'b010);
            end
            OP_IMMED: begin
                imm = imm_i;
                if (f3 == 3'b001) begin
                    illegal = (f7 != 7'h00);
                end else if (f3 == 3'b101) begin
                    illegal = (f7 != 7'h00) && (f7 != 7'h20);
                end
            end
            OP_REGREG: begin
                // funct7 0x20 is only meaningful for SUB (000) and SRA (101)
                illegal = !((f7 == 7'h00) ||
                            ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OP_SYSTEM: begin
                imm     = imm_i;
                illegal = (f3 == 3'b100);
            end
            OP_MISCMEM: begin
                imm     = imm_i;
                illegal = (f3 > 3'b001);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (head_instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
        if (illegal) begin
            imm = '0;
        end
    end

    always_comb begin
        dec_pc      = '0;
        dec_pc4     = '0;
        dec_pred    = '0;
        dec_opcode  = '0;
        dec_funct3  = '0;
        dec_funct7  = '0;
        dec_rd      = '0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        if (dec_valid) begin
            dec_pc      = pc_q[rd_ptr];
            dec_pc4     = pc4_q[rd_ptr];
            dec_pred    = pred_q[rd_ptr];
            dec_opcode  = op;
            dec_funct3  = f3;
            dec_funct7  = f7;
            dec_rd      = head_instr[11:7];
            dec_rs1     = head_instr[19:15];
            dec_rs2     = head_instr[24:20];
            dec_imm     = imm;
            dec_illegal = illegal;
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_decode_queue.sv
// Self-checking bench for rv32i_fetch_decode_queue: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_rv32i_fetch_decode_queue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned VW    = 163 + CW;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          flush;
    logic          fetch_token;
    logic          fetch_ready;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc4;
    logic [31:0]   fetch_instr;
    logic [31:0]   fetch_pred;
    logic          dec_valid;
    logic          dec_ready;
    logic [31:0]   dec_pc;
    logic [31:0]   dec_pc4;
    logic [31:0]   dec_pred;
    logic [6:0]    dec_opcode;
    logic [2:0]    dec_funct3;
    logic [6:0]    dec_funct7;
    logic [4:0]    dec_rd;
    logic [4:0]    dec_rs1;
    logic [4:0]    dec_rs2;
    logic [31:0]   dec_imm;
    logic          dec_illegal;
    logic [CW-1:0] count;

    rv32i_fetch_decode_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .fetch_token(fetch_token), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_pc4(fetch_pc4),
        .fetch_instr(fetch_instr), .fetch_pred(fetch_pred),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_pc4(dec_pc4), .dec_pred(dec_pred),
        .dec_opcode(dec_opcode), .dec_funct3(dec_funct3), .dec_funct7(dec_funct7),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_imm(dec_imm), .dec_illegal(dec_illegal), .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [31:0] pred;
    } pkt_t;

    pkt_t        mq[$];
    logic [31:0] obs_pops[$];
    logic [31:0] acc_pushes[$];
    int          checks = 0;
    int          errors = 0;

    logic [VW-1:0] act_vec;
    assign act_vec = {dec_valid, fetch_ready, count, dec_pc, dec_pc4, dec_pred,
                      dec_opcode, dec_funct3, dec_funct7, dec_rd, dec_rs1, dec_rs2,
                      dec_imm, dec_illegal};

    // Reference decode written straight from the RV32I format/legality rules.
    function automatic void ref_dec(input logic [31:0] i, output logic [31:0] imm,
                                    output logic ill);
        logic [2:0] f3;
        logic [6:0] f7;
        f3  = i[14:12];
        f7  = i[31:25];
        ill = 1'b0;
        imm = 32'h0;
        case (i[6:0])
            7'h37, 7'h17: imm = {i[31:12], 12'h000};
            7'h6F: imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            7'h67: begin imm = {{20{i[31]}}, i[31:20]}; ill = (f3 != 0); end
            7'h63: begin
                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                ill = (f3 inside {3'd2, 3'd3});
            end
            7'h03: begin imm = {{20{i[31]}}, i[31:20]}; ill = (f3 inside {3'd3, 3'd6, 3'd7}); end
            7'h23: begin imm = {{20{i[31]}}, i[31:25], i[11:7]}; ill = (f3 > 3'd2); end
            7'h13: begin
                imm = {{20{i[31]}}, i[31:20]};
                ill = (f3 == 3'd1 && f7 != 0) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}));
            end
            7'h33: ill = !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}));
            7'h73: begin imm = {{20{i[31]}}, i[31:20]}; ill = (f3 == 3'd4); end
            7'h0F: begin imm = {{20{i[31]}}, i[31:20]}; ill = (f3 > 3'd1); end
            default: ill = 1'b1;
        endcase
        if (ill) imm = 32'h0;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [31:0] imm;
        logic        ill;
        pkt_t        h;
        if (mq.size() == 0) return {1'b0, 1'b1, {(VW-2){1'b0}}};
        h = mq[0];
        ref_dec(h.instr, imm, ill);
        return {1'b1, 1'(mq.size() < DEPTH), CW'(mq.size()), h.pc, h.pc4, h.pred,
                h.instr[6:0], h.instr[14:12], h.instr[31:25], h.instr[11:7],
                h.instr[19:15], h.instr[24:20], imm, ill};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};
        logic [31:0] ins;
        int unsigned k;
        ins = $urandom;
        k   = $urandom_range(0, 13);
        if (k < 11) ins[6:0] = ops[k];
        if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return ins;
    endfunction

    // One clock: drive inputs, advance the model at the edge, settle 1 time unit.
    task automatic step(input logic tok, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl);
        pkt_t p;
        logic do_push, do_pop;
        fetch_token = tok;
        fetch_pc    = pc;
        fetch_pc4   = pc + 32'd4;
        fetch_instr = ins;
        fetch_pred  = $urandom;
        dec_ready   = rdy;
        flush       = fl;
        p       = '{pc, pc + 32'd4, ins, fetch_pred};
        do_push = tok && (mq.size() < DEPTH) && !fl;
        do_pop  = (mq.size() > 0) && rdy && !fl;
        if (do_pop) obs_pops.push_back(dec_pc);
        @(posedge CLK);
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(p);
                acc_pushes.push_back(pc);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; flush = 1'b0; fetch_token = 1'b0; dec_ready = 1'b0;
        fetch_pc = '0; fetch_pc4 = '0; fetch_instr = '0; fetch_pred = '0;
        mq.delete();
        #12;
        checks++;
        if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", act_vec, exp_vec());
        end
        checks++;
        if (fetch_ready !== 1'b1 || count !== '0) begin
            errors++; $display("FAIL reset_ready_count: got ready=%b count=%0d expected 1/0", fetch_ready, count);
        end
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_decode_examples();
        logic [31:0] ins  [5] = '{32'h00500093, 32'hFE000EE3, 32'h0080006F, 32'h123450B7, 32'h00000000};
        logic [31:0] imms [5] = '{32'h5, 32'hFFFFFFFC, 32'h8, 32'h12345000, 32'h0};
        logic [6:0]  opcs [5] = '{7'h13, 7'h63, 7'h6F, 7'h37, 7'h00};
        logic [4:0]  rds  [5] = '{5'd1, 5'd29, 5'd0, 5'd1, 5'd0};
        logic        ills [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 32'h100, ins[n], 1'b0, 1'b0);
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_pc4 !== 32'h104) begin
                errors++; $display("FAIL dec_head[%0d]: got valid=%b pc=%h pc4=%h expected 1/100/104", n, dec_valid, dec_pc, dec_pc4);
            end
            checks++;
            if (dec_opcode !== opcs[n] || dec_rd !== rds[n]) begin
                errors++; $display("FAIL dec_fields[%0d]: got op=%h rd=%0d expected %h/%0d", n, dec_opcode, dec_rd, opcs[n], rds[n]);
            end
            checks++;
            if (dec_imm !== imms[n] || dec_illegal !== ills[n]) begin
                errors++; $display("FAIL dec_imm[%0d]: got imm=%h ill=%b expected %h/%b", n, dec_imm, dec_illegal, imms[n], ills[n]);
            end
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL dec_model[%0d]: got %h expected %h", n, act_vec, exp_vec());
            end
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        checks++;
        if (dec_valid !== 1'b0 || dec_imm !== 32'h0 || dec_opcode !== 7'h0) begin
            errors++; $display("FAIL dec_empty: got valid=%b imm=%h op=%h expected 0/0/0", dec_valid, dec_imm, dec_opcode);
        end
    endtask

    task automatic test_full_backpressure();
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b1, 32'h2000 + 32'(4 * k), rand_instr(), 1'b0, 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL fill_model[%0d]: got %h expected %h", k, act_vec, exp_vec());
            end
        end
        checks++;
        if (fetch_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            errors++; $display("FAIL full_flags: got ready=%b count=%0d expected 0/%0d", fetch_ready, count, DEPTH);
        end
        step(1'b1, 32'h3000, rand_instr(), 1'b0, 1'b0);
        checks++;
        if (count !== CW'(DEPTH) || dec_pc !== 32'h2000) begin
            errors++; $display("FAIL full_extra_push: got count=%0d pc=%h expected %0d/2000", count, dec_pc, DEPTH);
        end
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (dec_pc !== 32'h2000 + 32'(4 * k)) begin
                errors++; $display("FAIL drain_order[%0d]: got %h expected %h", k, dec_pc, 32'h2000 + 32'(4 * k));
            end
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        checks++;
        if (dec_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++; $display("FAIL drain_empty: got valid=%b ready=%b expected 0/1", dec_valid, fetch_ready);
        end
    endtask

    task automatic test_back_to_back();
        obs_pops.delete();
        acc_pushes.delete();
        for (int k = 0; k < DEPTH; k++) step(1'b1, 32'h4000 + 32'(4 * k), rand_instr(), 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 32'h5000 + 32'(4 * k), rand_instr(), 1'b1, 1'b0);
            checks++;
            if (count !== CW'(DEPTH - 1) || act_vec !== exp_vec()) begin
                errors++; $display("FAIL b2b_cycle[%0d]: got count=%0d vec=%h expected %0d/%h", k, count, act_vec, DEPTH - 1, exp_vec());
            end
        end
        for (int k = 0; k < DEPTH + 2; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (obs_pops.size() != acc_pushes.size() || acc_pushes.size() != DEPTH + 7) begin
            errors++; $display("FAIL b2b_counts: got pops=%0d pushes=%0d expected %0d", obs_pops.size(), acc_pushes.size(), DEPTH + 7);
        end else begin
            for (int k = 0; k < obs_pops.size(); k++) begin
                checks++;
                if (obs_pops[k] !== acc_pushes[k]) begin
                    errors++; $display("FAIL b2b_order[%0d]: got %h expected %h", k, obs_pops[k], acc_pushes[k]);
                end
            end
        end
    endtask

    task automatic test_flush();
        step(1'b1, 32'h6000, rand_instr(), 1'b0, 1'b0);
        step(1'b1, 32'h6004, rand_instr(), 1'b0, 1'b0);
        step(1'b1, 32'h6008, rand_instr(), 1'b1, 1'b1);
        checks++;
        if (count !== '0 || dec_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: got count=%0d valid=%b ready=%b expected 0/0/1", count, dec_valid, fetch_ready);
        end
        step(1'b1, 32'h600C, rand_instr(), 1'b0, 1'b0);
        checks++;
        if (dec_pc !== 32'h600C || act_vec !== exp_vec()) begin
            errors++; $display("FAIL flush_refill: got pc=%h vec=%h expected 600c/%h", dec_pc, act_vec, exp_vec());
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) != 0), $urandom, rand_instr(),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h expected %h", k, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'h7000, rand_instr(), 1'b0, 1'b0);
        step(1'b1, 32'h7004, rand_instr(), 1'b0, 1'b0);
        fetch_token = 1'b0;
        dec_ready   = 1'b0;
        #2 nRST = 1'b0;
        mq.delete();
        #1;
        checks++;
        if (dec_valid !== 1'b0 || count !== '0 || fetch_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: got valid=%b count=%0d ready=%b expected 0/0/1", dec_valid, count, fetch_ready);
        end
        checks++;
        if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL async_reset_fields: got %h expected %h", act_vec, exp_vec());
        end
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;
        step(1'b1, 32'h7100, rand_instr(), 1'b0, 1'b0);
        checks++;
        if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL post_reset_push: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_decode_examples();
        test_full_backpressure();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
